// File: rtl/svga_timing_gen.sv
// svga_timing_gen: pixel position, display enable and sync generator.
// Two phase FSMs track the line/frame; outputs are registered per pixel.
module svga_timing_gen #(
  parameter int H_VIS  = 800,
  parameter int H_FP   = 40,
  parameter int H_SYNC = 128,
  parameter int H_BP   = 88,
  parameter int V_VIS  = 600,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 23,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_en,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  if (H_TOT > 4096 || V_TOT > 2048) begin : g_bad_totals
    $error("svga_timing_gen: H_TOT or V_TOT out of range");
  end

  localparam logic [11:0] H_ACT_END = 12'(H_VIS - 1);
  localparam logic [11:0] H_FP_END  = 12'(H_VIS + H_FP - 1);
  localparam logic [11:0] H_SYN_END = 12'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [11:0] H_LAST    = 12'(H_TOT - 1);

  localparam logic [10:0] V_ACT_END = 11'(V_VIS - 1);
  localparam logic [10:0] V_FP_END  = 11'(V_VIS + V_FP - 1);
  localparam logic [10:0] V_SYN_END = 11'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOT - 1);

  typedef enum logic [1:0] {
    PH_ACT,
    PH_FP,
    PH_SYN,
    PH_BP
  } phase_t;

  phase_t      h_ph;
  phase_t      h_ph_nxt;
  phase_t      h_ph_step;
  phase_t      v_ph;
  phase_t      v_ph_nxt;
  phase_t      v_ph_step;
  logic [11:0] h_ph_last;
  logic [10:0] v_ph_last;
  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_wrap;
  logic        v_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Phase registers for the horizontal and vertical FSMs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_ph <= PH_ACT;
      v_ph <= PH_ACT;
    end else begin
      h_ph <= h_ph_nxt;
      v_ph <= v_ph_nxt;
    end
  end

  // Horizontal phase advances on the last pixel of the current phase
  always_comb begin
    h_ph_last = H_ACT_END;
    h_ph_step = PH_FP;
    unique case (h_ph)
      PH_ACT: begin
        h_ph_last = H_ACT_END;
        h_ph_step = PH_FP;
      end
      PH_FP: begin
        h_ph_last = H_FP_END;
        h_ph_step = PH_SYN;
      end
      PH_SYN: begin
        h_ph_last = H_SYN_END;
        h_ph_step = PH_BP;
      end
      PH_BP: begin
        h_ph_last = H_LAST;
        h_ph_step = PH_ACT;
      end
    endcase
    h_ph_nxt = h_ph;
    if (pix_en && h_cnt == h_ph_last) begin
      h_ph_nxt = h_ph_step;
    end
  end

  // Vertical phase advances only at the end of the phase's last line
  always_comb begin
    v_ph_last = V_ACT_END;
    v_ph_step = PH_FP;
    unique case (v_ph)
      PH_ACT: begin
        v_ph_last = V_ACT_END;
        v_ph_step = PH_FP;
      end
      PH_FP: begin
        v_ph_last = V_FP_END;
        v_ph_step = PH_SYN;
      end
      PH_SYN: begin
        v_ph_last = V_SYN_END;
        v_ph_step = PH_BP;
      end
      PH_BP: begin
        v_ph_last = V_LAST;
        v_ph_step = PH_ACT;
      end
    endcase
    v_ph_nxt = v_ph;
    if (pix_en && h_wrap && v_cnt == v_ph_last) begin
      v_ph_nxt = v_ph_step;
    end
  end

  // Register the decode of the current position, then step the counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      x           <= h_cnt;
      y           <= v_cnt;
      de          <= (h_ph == PH_ACT) && (v_ph == PH_ACT);
      hsync       <= (h_ph == PH_SYN) ? HS_POL : ~HS_POL;
      vsync       <= (v_ph == PH_SYN) ? VS_POL : ~VS_POL;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
    end
  end

endmodule
